// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
//   - stall bus bit meanings and the four stall patterns the sequencer emits
//   - MDU sequencing FSM state encoding
//   - register-match helper used by the load-use detector
package pipeline_stall_ctrl_pkg;

  // Stall bus bit positions (bit = 1 holds that stage).
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall patterns. The highest held stage bubbles the stage after it:
  //   IF  : PC/IF held, bubble into ID
  //   LU  : PC/IF/ID held, bubble into EX
  //   MDU : PC..EX held, bubble into MEM
  localparam logic [5:0] STALL_CODE_NONE = 6'b000000;
  localparam logic [5:0] STALL_CODE_IF   = 6'b000011;
  localparam logic [5:0] STALL_CODE_LU   = 6'b000111;
  localparam logic [5:0] STALL_CODE_MDU  = 6'b001111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // True when a source operand that is actually read matches a destination.
  function automatic logic reg_hit(input logic       ren,
                                   input logic [4:0] src,
                                   input logic [4:0] dst);
    return ren && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall performance counters.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, clears the count
//   inc  - count this cycle
//   cnt  - current count; sticks at all-ones instead of wrapping
module sat_counter
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central pipeline sequencer producing the stall bus for PC/IF/ID/EX/MEM/WB.
// Detects ID/EX load-use hazards, sequences the shared mult/div unit while
// its instruction sits in EX, honours IF fetch stalls and flush, and keeps
// saturating per-cause stall counters.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   flush                    pipeline flush, dominates everything
//   stallreq_if              fetch not ready
//   id_valid, id_rs, id_rt,
//   id_rs_ren, id_rt_ren     ID instruction and its source operands
//   ex_valid, ex_is_load,
//   ex_rf_waddr              EX instruction, load flag, destination
//   ex_mdu_req, ex_mdu_is_div EX is a mult/div (and which)
//   div_done                 divider result ready pulse
//   stall                    stall bus (1 = stop)
//   mdu_start, mdu_is_div,
//   mdu_cancel, mdu_busy     MDU control / status
//   perf_lu_cnt, perf_mdu_cnt stall-cycle counters by cause
//
// MDU FSM:
//   state | meaning
//   IDLE  | no MDU op running; a valid EX mult/div starts one (EX stalls)
//   BUSY  | op running; mult counts latency down, div waits for div_done
//   DONE  | result available, EX released this edge; always back to IDLE
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int STALL_W = 6,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stallreq_if,
  input  logic               id_valid,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_ren,
  input  logic               id_rt_ren,
  input  logic               ex_valid,
  input  logic               ex_is_load,
  input  logic [4:0]         ex_rf_waddr,
  input  logic               ex_mdu_req,
  input  logic               ex_mdu_is_div,
  input  logic               div_done,
  output logic [STALL_W-1:0] stall,
  output logic               mdu_start,
  output logic               mdu_is_div,
  output logic               mdu_cancel,
  output logic               mdu_busy,
  output logic [CNT_W-1:0]   perf_lu_cnt,
  output logic [CNT_W-1:0]   perf_mdu_cnt
);

  // Latency down-counter only needs to hold MUL_LAT-1.
  localparam int              LAT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MUL_LAT - 1);

  mdu_state_e         state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               start_c;
  logic               cancel_c;
  logic               load_use;
  logic               mdu_hold;
  logic [STALL_W-1:0] stall_c;
  logic               lu_inc;
  logic               mdu_inc;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  always_comb begin
    load_use = id_valid && ex_valid && ex_is_load && (ex_rf_waddr != 5'd0) &&
               (reg_hit(id_rs_ren, id_rs, ex_rf_waddr) ||
                reg_hit(id_rt_ren, id_rt, ex_rf_waddr));
    // The start cycle itself already holds EX, before the FSM reaches BUSY.
    mdu_hold = ((state_q == MDU_IDLE) && ex_valid && ex_mdu_req) ||
               (state_q == MDU_BUSY);
  end

  // -------------------------------------------------------------------------
  // Stall mux
  // -------------------------------------------------------------------------
  always_comb begin
    stall_c = STALL_W'(STALL_CODE_NONE);
    if (flush) begin
      stall_c = STALL_W'(STALL_CODE_NONE);
    end else if (mdu_hold) begin
      stall_c = STALL_W'(STALL_CODE_MDU);
    end else if (load_use) begin
      stall_c = STALL_W'(STALL_CODE_LU);
    end else if (stallreq_if) begin
      stall_c = STALL_W'(STALL_CODE_IF);
    end
  end

  // -------------------------------------------------------------------------
  // MDU FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    start_c  = 1'b0;
    cancel_c = 1'b0;

    if (flush) begin
      state_d  = MDU_IDLE;
      cancel_c = (state_q == MDU_BUSY);
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (ex_valid && ex_mdu_req) begin
            start_c  = 1'b1;
            is_div_d = ex_mdu_is_div;
            cnt_d    = LAT_LOAD;
            state_d  = MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          if (is_div_q) begin
            // Divide has no timeout; only the divider ends it.
            if (div_done) begin
              state_d = MDU_DONE;
            end
          end else if (cnt_q == '0) begin
            state_d = MDU_DONE;
          end else begin
            cnt_d = cnt_q - LAT_W'(1);
          end
        end
        // ex_mdu_req is still visible here; returning to IDLE without a
        // restart lets the finished instruction leave EX.
        MDU_DONE: state_d = MDU_IDLE;
        default:  state_d = MDU_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all forced low while reset is asserted)
  // -------------------------------------------------------------------------
  assign stall      = rst ? '0 : stall_c;
  assign mdu_start  = !rst && start_c;
  assign mdu_cancel = !rst && cancel_c;
  assign mdu_busy   = !rst && (state_q != MDU_IDLE);
  assign mdu_is_div = is_div_q;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  // A load-use cycle only counts when load-use is what actually drove the bus.
  assign lu_inc  = !flush && !mdu_hold && load_use;
  assign mdu_inc = !flush && mdu_hold;

  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk (clk),
    .rst (rst),
    .inc (lu_inc),
    .cnt (perf_lu_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mdu_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mdu_inc),
    .cnt (perf_mdu_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam int STALL_W = 6;
  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 6;   // small so saturation is reachable
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IF   = 6'b000011;
  localparam logic [5:0] S_LU   = 6'b000111;
  localparam logic [5:0] S_MDU  = 6'b001111;

  typedef struct packed {
    logic       exv;
    logic       ld;
    logic [4:0] wa;
    logic       idv;
    logic [4:0] rs;
    logic       rs_ren;
    logic [4:0] rt;
    logic       rt_ren;
    logic       sreq;
    logic       flush;
    logic       req;
    logic       isdiv;
    logic       dd;
  } in_t;

  typedef struct packed {
    logic [5:0] stall;
    logic       start;
    logic       cancel;
    logic       busy;
    logic       isdiv;
    logic       lu_inc;
    logic       mdu_inc;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush, stallreq_if, id_valid, id_rs_ren, id_rt_ren;
  logic [4:0]         id_rs, id_rt, ex_rf_waddr;
  logic               ex_valid, ex_is_load, ex_mdu_req, ex_mdu_is_div, div_done;
  logic [STALL_W-1:0] stall;
  logic               mdu_start, mdu_is_div, mdu_cancel, mdu_busy;
  logic [CNT_W-1:0]   perf_lu_cnt, perf_mdu_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CNT_W-1:0] lu_acc  = '0;
  logic [CNT_W-1:0] mdu_acc = '0;
  exp_t exp_q[$];
  vec_t tbl[12];

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .STALL_W(STALL_W), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .stallreq_if(stallreq_if),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rf_waddr(ex_rf_waddr),
    .ex_mdu_req(ex_mdu_req), .ex_mdu_is_div(ex_mdu_is_div), .div_done(div_done),
    .stall(stall), .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
    .mdu_cancel(mdu_cancel), .mdu_busy(mdu_busy),
    .perf_lu_cnt(perf_lu_cnt), .perf_mdu_cnt(perf_mdu_cnt)
  );

  function automatic in_t mk_in(input logic exv, ld, input logic [4:0] wa,
                                input logic idv, input logic [4:0] rs,
                                input logic rs_ren, input logic [4:0] rt,
                                input logic rt_ren, sreq, fl, req, isdiv, dd);
    in_t r;
    r = '{exv, ld, wa, idv, rs, rs_ren, rt, rt_ren, sreq, fl, req, isdiv, dd};
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic [5:0] st, input logic start, cancel,
                                  busy, isdiv, lu_inc, mdu_inc);
    exp_t r;
    r = '{st, start, cancel, busy, isdiv, lu_inc, mdu_inc};
    return r;
  endfunction

  // Convenience stimulus for an EX mult/div request with nothing else going on.
  function automatic in_t mdu_in(input logic isdiv, dd, fl);
    return mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, fl, 1, isdiv, dd);
  endfunction

  task automatic apply(input in_t i);
    ex_valid = i.exv;  ex_is_load = i.ld;   ex_rf_waddr = i.wa;
    id_valid = i.idv;  id_rs = i.rs;        id_rs_ren = i.rs_ren;
    id_rt = i.rt;      id_rt_ren = i.rt_ren;
    stallreq_if = i.sreq; flush = i.flush;
    ex_mdu_req = i.req; ex_mdu_is_div = i.isdiv; div_done = i.dd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req)
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    else
      n_pass++;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at negedge,
  // then advance the perf-count expectations for the coming edge.
  task automatic step(input string nm, input in_t i, input exp_t e);
    exp_t x;
    apply(i);
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    chk({nm, ".stall"},  32'(stall),        32'(x.stall));
    chk({nm, ".start"},  32'(mdu_start),    32'(x.start));
    chk({nm, ".cancel"}, 32'(mdu_cancel),   32'(x.cancel));
    chk({nm, ".busy"},   32'(mdu_busy),     32'(x.busy));
    chk({nm, ".is_div"}, 32'(mdu_is_div),   32'(x.isdiv));
    chk({nm, ".lu_cnt"}, 32'(perf_lu_cnt),  32'(lu_acc));
    chk({nm, ".mdu_cnt"},32'(perf_mdu_cnt), 32'(mdu_acc));
    if (x.lu_inc  && lu_acc  != CNT_MAX) lu_acc  = lu_acc  + 1'b1;
    if (x.mdu_inc && mdu_acc != CNT_MAX) mdu_acc = mdu_acc + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".stall"},   32'(stall),        0);
    chk({nm, ".start"},   32'(mdu_start),    0);
    chk({nm, ".cancel"},  32'(mdu_cancel),   0);
    chk({nm, ".busy"},    32'(mdu_busy),     0);
    chk({nm, ".is_div"},  32'(mdu_is_div),   0);
    chk({nm, ".lu_cnt"},  32'(perf_lu_cnt),  0);
    chk({nm, ".mdu_cnt"}, 32'(perf_mdu_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t idle;
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            name            exv ld wa idv rs rsr rt rtr sreq fl req dv dd
    tbl[0]  = '{"idle",        mk_in(0,0,0, 0,0,0, 0,0, 0,0, 0,0,0), mk_exp(S_NONE,0,0,0,0,0,0)};
    tbl[1]  = '{"lu_rs",       mk_in(1,1,2, 1,2,1, 4,1, 0,0, 0,0,0), mk_exp(S_LU,  0,0,0,0,1,0)};
    tbl[2]  = '{"lw_r0",       mk_in(1,1,0, 1,0,1, 0,1, 0,0, 0,0,0), mk_exp(S_NONE,0,0,0,0,0,0)};
    tbl[3]  = '{"if_only",     mk_in(0,0,0, 0,0,0, 0,0, 1,0, 0,0,0), mk_exp(S_IF,  0,0,0,0,0,0)};
    tbl[4]  = '{"lu_rt",       mk_in(1,1,7, 1,3,1, 7,1, 0,0, 0,0,0), mk_exp(S_LU,  0,0,0,0,1,0)};
    tbl[5]  = '{"rt_no_ren",   mk_in(1,1,7, 1,3,1, 7,0, 1,0, 0,0,0), mk_exp(S_IF,  0,0,0,0,0,0)};
    tbl[6]  = '{"id_invalid",  mk_in(1,1,5, 0,5,1, 0,0, 0,0, 0,0,0), mk_exp(S_NONE,0,0,0,0,0,0)};
    tbl[7]  = '{"ex_not_load", mk_in(1,0,5, 1,5,1, 0,0, 0,0, 0,0,0), mk_exp(S_NONE,0,0,0,0,0,0)};
    tbl[8]  = '{"lu_flush",    mk_in(1,1,5, 1,5,1, 0,0, 1,1, 0,0,0), mk_exp(S_NONE,0,0,0,0,0,0)};
    tbl[9]  = '{"lu_over_if",  mk_in(1,1,9, 1,9,0, 9,1, 1,0, 0,0,0), mk_exp(S_LU,  0,0,0,0,1,0)};
    tbl[10] = '{"ex_invalid",  mk_in(0,1,9, 1,9,1, 9,1, 0,0, 0,0,0), mk_exp(S_NONE,0,0,0,0,0,0)};
    tbl[11] = '{"rs_mismatch", mk_in(1,1,9, 1,8,1, 8,1, 1,0, 0,0,0), mk_exp(S_IF,  0,0,0,0,0,0)};

    // Reset: outputs low even with hazards and an MDU request presented.
    rst = 1'b1;
    apply(mk_in(1, 1, 2, 1, 2, 1, 0, 0, 1, 0, 1, 1, 0));
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    apply(idle);
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) step(tbl[k].name, tbl[k].i, tbl[k].e);

    // Mult with a load-use in the start cycle; div_done mid-mult is ignored.
    step("mul_c0", mk_in(1, 1, 2, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0),
         mk_exp(S_MDU, 1, 0, 0, 0, 0, 1));
    for (int k = 1; k <= MUL_LAT; k++)
      step("mul_busy", mdu_in(0, (k == 2), 0), mk_exp(S_MDU, 0, 0, 1, 0, 0, 1));
    step("mul_done", mdu_in(0, 0, 0), mk_exp(S_NONE, 0, 0, 1, 0, 0, 0));
    step("mul_idle", idle, mk_exp(S_NONE, 0, 0, 0, 0, 0, 0));

    // Div: div_done in IDLE ignored, real div_done on 33rd busy cycle.
    step("div_c0", mdu_in(1, 1, 0), mk_exp(S_MDU, 1, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 33; k++)
      step("div_busy", mdu_in(1, (k == 33), 0), mk_exp(S_MDU, 0, 0, 1, 1, 0, 1));
    step("div_done", mdu_in(1, 0, 0), mk_exp(S_NONE, 0, 0, 1, 1, 0, 0));
    step("div_idle", idle, mk_exp(S_NONE, 0, 0, 0, 1, 0, 0));
    chk("div_perf_total", 32'(perf_mdu_cnt), 32'd39);

    // Flush during BUSY cancels; flush in IDLE suppresses the start.
    step("fl_c0",     mdu_in(0, 0, 0), mk_exp(S_MDU, 1, 0, 0, 1, 0, 1));
    step("fl_busy",   mdu_in(0, 0, 0), mk_exp(S_MDU, 0, 0, 1, 0, 0, 1));
    step("fl_cancel", mdu_in(0, 0, 1), mk_exp(S_NONE, 0, 1, 1, 0, 0, 0));
    step("fl_after",  idle,            mk_exp(S_NONE, 0, 0, 0, 0, 0, 0));
    step("fl_idle",   mdu_in(0, 0, 1), mk_exp(S_NONE, 0, 0, 0, 0, 0, 0));
    step("fl_idle2",  idle,            mk_exp(S_NONE, 0, 0, 0, 0, 0, 0));

    // Long divide drives perf_mdu_cnt into saturation.
    step("sat_c0", mdu_in(1, 0, 0), mk_exp(S_MDU, 1, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 25; k++)
      step("sat_busy", mdu_in(1, 0, 0), mk_exp(S_MDU, 0, 0, 1, 1, 0, 1));
    step("sat_flush", mdu_in(1, 0, 1), mk_exp(S_NONE, 0, 1, 1, 1, 0, 0));
    step("sat_idle",  idle,            mk_exp(S_NONE, 0, 0, 0, 1, 0, 0));
    chk("sat_value", 32'(perf_mdu_cnt), 32'(CNT_MAX));

    // Reset mid-op: immediate IDLE, no cancel even with flush present.
    step("rst_c0",   mdu_in(0, 0, 0), mk_exp(S_MDU, 1, 0, 0, 1, 0, 1));
    step("rst_busy", mdu_in(0, 0, 0), mk_exp(S_MDU, 0, 0, 1, 0, 0, 1));
    apply(mk_in(1, 1, 2, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    apply(idle);
    lu_acc  = '0;
    mdu_acc = '0;
    @(posedge clk); #1;
    step("post_rst", idle, mk_exp(S_NONE, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
